// File: rtl/inst_sram_axi_rd.sv
// inst_sram_axi_rd: takes one fetch request at a time, turns it into a single-beat AXI4 read, and returns the instruction word.
module inst_sram_axi_rd #(
  parameter logic [3:0] AXI_ID      = 4'd0,
  parameter bit         ERR_CHK_RID = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_en,
  input  logic [3:0]  req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_addr_ok,
  output logic        req_data_ok,
  output logic [31:0] req_rdata,
  output logic        req_err,
  input  logic        cancel,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);
  typedef enum logic [1:0] {IDLE, AR, R} state_t;
  state_t      state_q, state_d;
  logic [31:0] araddr_q, araddr_d, rdata_q, rdata_d;
  logic        discard_q, discard_d, ok_q, ok_d, ill_q, ill_d, err_q, err_d;
  logic        legal, unused_ok;
  assign unused_ok = ^{req_wdata, rlast};
  assign legal = (req_we == 4'd0) && (req_addr[1:0] == 2'd0);
  always_comb begin
    state_d   = state_q;
    araddr_d  = araddr_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    discard_d = discard_q;
    ok_d      = 1'b0;
    ill_d     = 1'b0;
    case (state_q)
      IDLE: if (req_en) begin
        if (legal) begin
          araddr_d  = req_addr;
          discard_d = 1'b0;
          state_d   = AR;
        end else begin
          ok_d    = 1'b1;
          ill_d   = 1'b1;
          rdata_d = 32'd0;
          err_d   = 1'b1;
        end
      end
      AR: begin
        discard_d = discard_q | cancel;
        if (arready) state_d = R;
      end
      R: begin
        discard_d = discard_q | cancel;
        if (rvalid) begin
          rdata_d = rdata;
          err_d   = (rresp != 2'b00) | (ERR_CHK_RID & (rid != AXI_ID));
          ok_d    = ~(discard_q | cancel);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      araddr_q  <= 32'd0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
      discard_q <= 1'b0;
      ok_q      <= 1'b0;
      ill_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      araddr_q  <= araddr_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      discard_q <= discard_d;
      ok_q      <= ok_d;
      ill_q     <= ill_d;
    end
  end
  // an illegal-request response is still withdrawable by a flush in its own cycle
  assign req_data_ok = ok_q & ~(ill_q & cancel);
  assign req_addr_ok = state_q == IDLE;
  assign req_rdata   = rdata_q;
  assign req_err     = err_q;
  assign arvalid     = state_q == AR;
  assign rready      = state_q == R;
  assign araddr      = araddr_q;
  assign arid        = AXI_ID;
  assign arlen       = 8'd0;
  assign arsize      = 3'b010;
  assign arburst     = 2'b01;
endmodule

// File: tb/tb_inst_sram_axi_rd.sv
// tb_inst_sram_axi_rd: transaction-level checks of the fetch responder against timing derived from handshake delays.
module tb_inst_sram_axi_rd;
  logic        clk = 1'b0, rstn = 1'b0;
  logic        req_en = 1'b0, cancel = 1'b0, arready = 1'b0, rvalid = 1'b0, rlast = 1'b1;
  logic [3:0]  req_we = 4'd0, rid = 4'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0, rdata = 32'd0;
  logic [1:0]  rresp = 2'd0;
  logic        req_addr_ok, req_data_ok, req_err, arvalid, rready;
  logic [31:0] req_rdata, araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  int vectors = 0, errors = 0;

  inst_sram_axi_rd dut (
    .clk(clk), .rstn(rstn), .req_en(req_en), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_addr_ok(req_addr_ok), .req_data_ok(req_data_ok),
    .req_rdata(req_rdata), .req_err(req_err), .cancel(cancel), .arid(arid),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One request with cycle 0 = accept cycle; every output is predicted per cycle from the delays.
  task automatic fetch(input logic [31:0] addr, input logic [3:0] we, input int ard, input int rd,
                       input logic [1:0] resp, input logic [3:0] id, input int ccyc, input logic [31:0] word);
    bit legal = (we == 4'd0) && (addr[1:0] == 2'd0);
    int lat = legal ? 3 + ard + rd : 1;
    bit drop = legal ? (ccyc >= 1 && ccyc <= 2 + ard + rd) : (ccyc == 1);
    logic [31:0] exp_word = legal ? word : 32'd0;
    bit exp_err = !legal || resp != 2'b00 || id != 4'd0;
    for (int c = 0; c <= lat + 1; c++) begin
      @(negedge clk);
      req_en   = (c == 0);
      req_addr = addr;
      req_we   = we;
      cancel   = (c == ccyc);
      arready  = (c >= 1 + ard);
      rvalid   = (c >= 2 + ard + rd);
      rdata    = word;
      rresp    = resp;
      rid      = id;
      #1;
      chk("data_ok", req_data_ok, (c == lat) && !drop);
      chk("addr_ok", req_addr_ok, !(legal && c >= 1 && c < lat));
      chk("arvalid", arvalid, legal && c >= 1 && c <= 1 + ard);
      chk("rready", rready, legal && c >= 2 + ard && c <= 2 + ard + rd);
      if (legal && c >= 1 && c <= 1 + ard) begin
        chk("araddr", araddr, addr);
        chk("ar_const", {arid, arlen, arsize, arburst}, {4'd0, 8'd0, 3'b010, 2'b01});
      end
      if (c == lat && !drop) begin
        chk("rdata", req_rdata, exp_word);
        chk("err", req_err, exp_err);
      end
    end
    req_en = 1'b0; cancel = 1'b0; arready = 1'b0; rvalid = 1'b0;
  endtask

  task automatic reset_mid_r();
    @(negedge clk);
    req_en = 1'b1; req_addr = 32'h1C00_0200; req_we = 4'd0;
    @(negedge clk);
    req_en = 1'b0; arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    #1;
    chk("mid_rready_before", rready, 1'b1);
    rstn = 1'b0;
    #1;
    chk("rst_rready", rready, 1'b0);
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_data_ok", req_data_ok, 1'b0);
    chk("rst_addr_ok", req_addr_ok, 1'b1);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_addr_ok", req_addr_ok, 1'b1);
    chk("rst_data_ok", req_data_ok, 1'b0);
    chk("rst_rdata", req_rdata, 32'd0);
    chk("rst_err", req_err, 1'b0);
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_rready", rready, 1'b0);
    chk("rst_araddr", araddr, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    fetch(32'h1C00_0000, 4'h0, 0, 0, 2'b00, 4'h0, -1, 32'h0280_0C0C);
    fetch(32'h1C00_0004, 4'h0, 4, 5, 2'b00, 4'h0, -1, 32'h1234_5678);
    fetch(32'h1C00_0010, 4'h0, 1, 1, 2'b00, 4'h0, 1, 32'hDEAD_BEEF);
    fetch(32'h1C00_0100, 4'h0, 0, 0, 2'b00, 4'h0, -1, 32'h0011_2233);
    fetch(32'h1C00_0008, 4'hF, 0, 0, 2'b00, 4'h0, -1, 32'hAAAA_AAAA);
    fetch(32'h1C00_0002, 4'h0, 0, 0, 2'b00, 4'h0, -1, 32'hBBBB_BBBB);
    fetch(32'h1C00_0001, 4'h0, 0, 0, 2'b00, 4'h0, 1, 32'hCCCC_CCCC);
    fetch(32'h1C00_0020, 4'h0, 0, 1, 2'b10, 4'h0, -1, 32'h5555_0001);
    fetch(32'h1C00_0024, 4'h0, 1, 0, 2'b00, 4'h3, -1, 32'h5555_0002);
    fetch(32'h1C00_0028, 4'h0, 1, 2, 2'b00, 4'h0, 5, 32'h5555_0003);
    fetch(32'h1C00_002C, 4'h0, 0, 0, 2'b00, 4'h0, 0, 32'h5555_0004);
    fetch(32'h1C00_0030, 4'h0, 1, 1, 2'b00, 4'h0, 5, 32'h5555_0005);
    reset_mid_r();
    fetch(32'h1C00_0040, 4'h0, 0, 0, 2'b00, 4'h0, -1, 32'h0BAD_F00D);
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a = {$urandom} & 32'hFFFF_FFFC;
      logic [3:0]  w = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      int          cc = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 10) : -1;
      if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
      fetch(a, w, $urandom_range(0, 4), $urandom_range(0, 4),
            ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
            ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'd0, cc, $urandom);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
